// File: rtl/avl_led_output.sv
// Avalon-MM output register with atomic set/clear and a per-bit blink engine.
// The HPS writes over the lightweight bridge, and leds drives the board pins.
module avl_led_output #(
    parameter int WIDTH     = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             FPGA_CLK1_50,
    input  logic             reset,
    input  logic [1:0]       avl_address,
    input  logic             avl_write,
    input  logic [31:0]      avl_writedata,
    input  logic             avl_read,
    output logic [31:0]      avl_readdata,
    output logic [WIDTH-1:0] leds
);

    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_SET   = 2'd1,
        ADDR_CLR   = 2'd2,
        ADDR_BLINK = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] leds_q,  leds_d;

    logic [WIDTH-1:0] wd;
    logic             unused_wd_bits;

    assign wd             = avl_writedata[WIDTH-1:0];
    assign unused_wd_bits = ^avl_writedata[31:WIDTH];

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        data_d  = data_q;
        mask_d  = mask_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A BLINK write restarts the half-period and overrides a coincident wrap.
        if (avl_write) begin
            case (reg_addr_e'(avl_address))
                ADDR_DATA:  data_d = wd;
                ADDR_SET:   data_d = data_q | wd;
                ADDR_CLR:   data_d = data_q & ~wd;
                ADDR_BLINK: begin
                    mask_d  = wd;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Reads see the current (pre-write) state.
        if (avl_read) begin
            rdata_d = '0;
            if (reg_addr_e'(avl_address) == ADDR_BLINK) begin
                rdata_d[WIDTH-1:0] = mask_q;
                rdata_d[31]        = phase_q;
            end else begin
                rdata_d[WIDTH-1:0] = data_q;
            end
        end

        leds_d = data_q & ~(mask_q & {WIDTH{phase_q}});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            data_q  <= '0;
            mask_q  <= '0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            leds_q  <= '0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
        end
    end

    assign avl_readdata = rdata_q;
    assign leds         = leds_q;

endmodule
